csr_exec: RTL

Sequencing unit that executes Zicsr instructions and trap entry against the single-port machine/user CSR register file. It accepts a decoded CSR request from the execute stage and performs the read, the optional read-modify-write, and legality checks. It also runs the trap-entry sequence: write mepc, mcause and mtval, then fetch mtvec. It is the initiator on the CSR access port (addr/wdata/we out, rdata/valid in).

---
 rtl/csr_exec.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/csr_exec.sv
//------------------------------------------------------------------------------
// csr_exec : Zicsr execution and trap-entry sequencer for the CSR access port.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module csr_exec #(
    parameter logic [1:0] RO_TOP = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [11:0] req_addr,
    input  logic [4:0]  req_rs1_idx,
    input  logic [31:0] req_rs1_data,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_illegal,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_tval,
    output logic        trap_done,
    output logic [31:0] trap_target,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic        csr_we,
    input  logic [31:0] csr_rdata,
    input  logic        csr_valid
);

    localparam logic [11:0] C_MTVEC  = 12'h305;
    localparam logic [11:0] C_MEPC   = 12'h341;
    localparam logic [11:0] C_MCAUSE = 12'h342;
    localparam logic [11:0] C_MTVAL  = 12'h343;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RD      = 4'd1,
        S_WR      = 4'd2,
        S_RESP    = 4'd3,
        S_T_EPC   = 4'd4,
        S_T_CAUSE = 4'd5,
        S_T_TVAL  = 4'd6,
        S_T_VEC   = 4'd7,
        S_T_DONE  = 4'd8
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [2:0]  r_funct3;
    logic [11:0] r_addr;
    logic [4:0]  r_rs1_idx;
    logic [31:0] r_rs1_data;
    logic [31:0] r_old;
    logic        r_illegal;
    logic [31:0] r_tpc;
    logic [31:0] r_tcause;
    logic [31:0] r_ttval;
    logic [31:0] r_vec;

    logic [31:0] w_src;
    logic        w_wr_intent;
    logic        w_illegal;

    // Immediate forms take the zero-extended rs1 field as the operand.
    assign w_src       = r_funct3[2] ? {27'b0, r_rs1_idx} : r_rs1_data;
    assign w_wr_intent = (r_funct3[1:0] == 2'b01) || (r_rs1_idx != 5'd0);
    assign w_illegal   = (r_funct3[1:0] == 2'b00) || !csr_valid ||
                         (w_wr_intent && (r_addr[11:10] == RO_TOP));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_funct3   <= 3'd0;
            r_addr     <= 12'd0;
            r_rs1_idx  <= 5'd0;
            r_rs1_data <= 32'd0;
            r_old      <= 32'd0;
            r_illegal  <= 1'b0;
            r_tpc      <= 32'd0;
            r_tcause   <= 32'd0;
            r_ttval    <= 32'd0;
            r_vec      <= 32'd0;
        end else begin
            if (r_state == S_IDLE) begin
                if (trap_valid) begin
                    r_tpc    <= trap_pc;
                    r_tcause <= trap_cause;
                    r_ttval  <= trap_tval;
                end else if (req_valid) begin
                    r_funct3   <= req_funct3;
                    r_addr     <= req_addr;
                    r_rs1_idx  <= req_rs1_idx;
                    r_rs1_data <= req_rs1_data;
                end
            end
            if (r_state == S_RD) begin
                r_old     <= csr_rdata;
                r_illegal <= w_illegal;
            end
            if (r_state == S_T_VEC) begin
                r_vec <= csr_rdata;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_rdata   = 32'd0;
        resp_illegal = 1'b0;
        trap_done    = 1'b0;
        trap_target  = 32'd0;
        csr_addr     = 12'd0;
        csr_wdata    = 32'd0;
        csr_we       = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = !trap_valid;
                if (trap_valid) begin
                    w_next = S_T_EPC;
                end else if (req_valid) begin
                    w_next = S_RD;
                end
            end
            S_RD: begin
                csr_addr = r_addr;
                if (!w_illegal && w_wr_intent) begin
                    w_next = S_WR;
                end else begin
                    w_next = S_RESP;
                end
            end
            S_WR: begin
                csr_addr = r_addr;
                csr_we   = 1'b1;
                case (r_funct3[1:0])
                    2'b01:   csr_wdata = w_src;
                    2'b10:   csr_wdata = r_old | w_src;
                    2'b11:   csr_wdata = r_old & ~w_src;
                    default: csr_wdata = 32'd0;
                endcase
                w_next = S_RESP;
            end
            S_RESP: begin
                resp_valid   = 1'b1;
                resp_rdata   = r_illegal ? 32'd0 : r_old;
                resp_illegal = r_illegal;
                w_next       = S_IDLE;
            end
            S_T_EPC: begin
                csr_addr  = C_MEPC;
                csr_wdata = r_tpc;
                csr_we    = 1'b1;
                w_next    = S_T_CAUSE;
            end
            S_T_CAUSE: begin
                csr_addr  = C_MCAUSE;
                csr_wdata = r_tcause;
                csr_we    = 1'b1;
                w_next    = S_T_TVAL;
            end
            S_T_TVAL: begin
                csr_addr  = C_MTVAL;
                csr_wdata = r_ttval;
                csr_we    = 1'b1;
                w_next    = S_T_VEC;
            end
            S_T_VEC: begin
                csr_addr = C_MTVEC;
                w_next   = S_T_DONE;
            end
            S_T_DONE: begin
                trap_done   = 1'b1;
                trap_target = {r_vec[31:2], 2'b00};
                w_next      = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // While reset is held nothing may reach the CSR port or the consumers,
        // so a write in flight is dropped rather than committed on the reset edge.
        if (rst) begin
            req_ready    = 1'b0;
            resp_valid   = 1'b0;
            resp_rdata   = 32'd0;
            resp_illegal = 1'b0;
            trap_done    = 1'b0;
            trap_target  = 32'd0;
            csr_addr     = 12'd0;
            csr_wdata    = 32'd0;
            csr_we       = 1'b0;
        end
    end

endmodule

`default_nettype wire
